// File: rtl/byte_frame_loader.sv
// byte_frame_loader: collects one DEPTH-byte frame from a valid/ready stream into the
// source RAM, kicks the byte-to-word transfer FSM with a one-cycle op_mode pulse, and
// waits for its done flag before accepting the next frame.
// Optional build macro LOADER_TIMEOUT_EN adds a WAIT_DONE watchdog that aborts the
// frame after TIMEOUT cycles and raises the sticky err_timeout flag.
module byte_frame_loader #(
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_add,
    output logic [7:0]    data_wr,
    output logic          op_mode,
    input  logic          done,
    output logic          busy,
    output logic          frame_done,
    output logic          err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        WAIT_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state, state_n;
    logic [AW-1:0] wptr, wptr_n;
    logic          wr_en_n;
    logic [AW-1:0] wr_add_n;
    logic [7:0]    data_wr_n;
    logic          op_mode_n;
    logic          frame_done_n;
    logic          err_timeout_n;
    logic          accept;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcount, tcount_n;
`endif

    // Only IDLE and LOAD can take bytes; anything past IDLE counts as a frame in flight.
    assign in_ready = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // State register plus every registered output; reset is synchronous and never touches RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wptr        <= '0;
            wr_en       <= 1'b0;
            wr_add      <= '0;
            data_wr     <= 8'h00;
            op_mode     <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tcount      <= '0;
`endif
        end else begin
            state       <= state_n;
            wptr        <= wptr_n;
            wr_en       <= wr_en_n;
            wr_add      <= wr_add_n;
            data_wr     <= data_wr_n;
            op_mode     <= op_mode_n;
            frame_done  <= frame_done_n;
            err_timeout <= err_timeout_n;
`ifdef LOADER_TIMEOUT_EN
            tcount      <= tcount_n;
`endif
        end
    end

    // Next-state and next-output decode; done is only looked at in WAIT_DONE so a stale flag is dropped.
    always_comb begin
        state_n       = state;
        wptr_n        = wptr;
        wr_en_n       = 1'b0;
        wr_add_n      = wr_add;
        data_wr_n     = data_wr;
        op_mode_n     = 1'b0;
        frame_done_n  = 1'b0;
        err_timeout_n = err_timeout;
`ifdef LOADER_TIMEOUT_EN
        tcount_n      = tcount;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    wr_en_n       = 1'b1;
                    wr_add_n      = '0;
                    data_wr_n     = in_data;
                    wptr_n        = AW'(1);
                    err_timeout_n = 1'b0;
                    state_n       = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_n   = 1'b1;
                    wr_add_n  = wptr;
                    data_wr_n = in_data;
                    if (wptr == LAST_ADDR) begin
                        state_n = DRAIN;
                    end else begin
                        wptr_n = wptr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                op_mode_n = 1'b1;
                state_n   = START;
            end
            START: begin
`ifdef LOADER_TIMEOUT_EN
                tcount_n = '0;
`endif
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    frame_done_n = 1'b1;
                    wptr_n       = '0;
                    state_n      = IDLE;
`ifdef LOADER_TIMEOUT_EN
                end else if (tcount == TIMEOUT_LAST) begin
                    err_timeout_n = 1'b1;
                    wptr_n        = '0;
                    state_n       = IDLE;
                end else begin
                    tcount_n = tcount + 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_frame_loader.sv
// tb_byte_frame_loader: directed self-checking bench for byte_frame_loader (DEPTH=32, TIMEOUT=64).
module tb_byte_frame_loader;

    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 64;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_add;
    logic [7:0]    data_wr;
    logic          op_mode;
    logic          done;
    logic          busy;
    logic          frame_done;
    logic          err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    byte_frame_loader #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_add      (wr_add),
        .data_wr     (data_wr),
        .op_mode     (op_mode),
        .done        (done),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream a full frame with in_valid held high; bytes are base+i. Ends in the DRAIN cycle.
    task automatic stream_frame(input string tag, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = base + 8'(i);
            apply_stimulus(1'b1, b);
            check_output({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
            tick();
            check_output({tag, "_wr_en"}, 32'(wr_en), 32'd1);
            check_output({tag, "_wr_add"}, 32'(wr_add), 32'(i));
            check_output({tag, "_data_wr"}, 32'(data_wr), 32'(b));
            check_output({tag, "_op_mode_quiet"}, 32'(op_mode), 32'd0);
            check_output({tag, "_in_ready_post"}, 32'(in_ready), (i == DEPTH - 1) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        int k;
        int cyc;
        logic acc;
        logic [7:0] b;

        rst_n    = 1'b0;
        done     = 1'b0;
        apply_stimulus(1'b0, 8'h00);

        // Test 1: reset held two cycles, then again with in_valid high.
        tick();
        tick();
        check_output("rst_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_wr_add", 32'(wr_add), 32'd0);
        check_output("rst_data_wr", 32'(data_wr), 32'd0);
        check_output("rst_op_mode", 32'(op_mode), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_err_timeout", 32'(err_timeout), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b1, 8'h55);
        tick();
        tick();
        check_output("rst_valid_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_valid_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 8'h00);
        rst_n = 1'b1;
        tick();
        check_output("idle_wr_en", 32'(wr_en), 32'd0);

        // Test 2: back-to-back frame 0x00..0x1F, junk offered while draining must be ignored.
        $display("[TB] back-to-back frame");
        stream_frame("t2", 8'h00);
        apply_stimulus(1'b1, 8'hEE);
        tick();
        check_output("t2_start_op_mode", 32'(op_mode), 32'd1);
        check_output("t2_start_wr_en", 32'(wr_en), 32'd0);
        check_output("t2_start_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_output("t2_wait_op_mode", 32'(op_mode), 32'd0);
        check_output("t2_wait_busy", 32'(busy), 32'd1);
        check_output("t2_wait_wr_en", 32'(wr_en), 32'd0);
        apply_stimulus(1'b0, 8'h00);
        tick();
        done = 1'b1;
        tick();
        check_output("t2_frame_done", 32'(frame_done), 32'd1);
        check_output("t2_fd_busy", 32'(busy), 32'd0);
        check_output("t2_fd_in_ready", 32'(in_ready), 32'd1);

        // Tests 3 and 4: random gaps with a stale done held through the frame.
        $display("[TB] gapped frame with stale done");
        tick();
        check_output("t3_fd_pulse_end", 32'(frame_done), 32'd0);
        check_output("t3_idle_stale_done", 32'(busy), 32'd0);
        k   = 0;
        cyc = 0;
        while (k < DEPTH && cyc < 400) begin
            acc = 1'(($urandom_range(0, 1)));
            b   = 8'hA0 + 8'(k);
            apply_stimulus(acc, b);
            tick();
            cyc++;
            check_output("t3_wr_en", 32'(wr_en), 32'(acc));
            if (acc) begin
                check_output("t3_wr_add", 32'(wr_add), 32'(k));
                check_output("t3_data_wr", 32'(data_wr), 32'(b));
                k++;
            end
            check_output("t3_frame_done_quiet", 32'(frame_done), 32'd0);
        end
        check_output("t3_write_count", 32'(k), 32'(DEPTH));
        apply_stimulus(1'b0, 8'h00);
        check_output("t3_drain_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_output("t4_start_op_mode", 32'(op_mode), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_output("t4_stale_frame_done", 32'(frame_done), 32'd0);
            check_output("t4_wait_busy", 32'(busy), 32'd1);
        end
        done = 1'b1;
        tick();
        check_output("t4_frame_done", 32'(frame_done), 32'd1);
        check_output("t4_busy", 32'(busy), 32'd0);
        check_output("t4_in_ready", 32'(in_ready), 32'd1);
        done = 1'b0;
        tick();
        check_output("t4_frame_done_once", 32'(frame_done), 32'd0);

        // Test 5: abort a partial frame with reset, then load a fresh frame.
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 8'h30 + 8'(i));
            tick();
        end
        check_output("t5_partial_wr_add", 32'(wr_add), 32'd9);
        apply_stimulus(1'b0, 8'h00);
        rst_n = 1'b0;
        tick();
        check_output("t5_rst_busy", 32'(busy), 32'd0);
        check_output("t5_rst_wr_add", 32'(wr_add), 32'd0);
        rst_n = 1'b1;
        tick();
        stream_frame("t5", 8'h60);
        apply_stimulus(1'b0, 8'h00);
        tick();
        check_output("t5_start_op_mode", 32'(op_mode), 32'd1);
        tick();

`ifdef LOADER_TIMEOUT_EN
        // Test 6: done never comes, watchdog aborts after TIMEOUT WAIT_DONE cycles.
        $display("[TB] timeout abort");
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check_output("t6_wait_busy", 32'(busy), 32'd1);
            check_output("t6_wait_err", 32'(err_timeout), 32'd0);
        end
        tick();
        check_output("t6_err_timeout", 32'(err_timeout), 32'd1);
        check_output("t6_busy", 32'(busy), 32'd0);
        check_output("t6_no_frame_done", 32'(frame_done), 32'd0);
        apply_stimulus(1'b1, 8'h77);
        tick();
        check_output("t6_next_wr_add", 32'(wr_add), 32'd0);
        check_output("t6_next_data_wr", 32'(data_wr), 32'h77);
        check_output("t6_err_cleared", 32'(err_timeout), 32'd0);
        apply_stimulus(1'b0, 8'h00);
`else
        // Without the watchdog the loader waits for done indefinitely.
        $display("[TB] indefinite wait");
        for (int i = 0; i < 100; i++) begin
            tick();
            check_output("t6_wait_busy", 32'(busy), 32'd1);
            check_output("t6_err_stays_low", 32'(err_timeout), 32'd0);
        end
        done = 1'b1;
        tick();
        check_output("t6_late_frame_done", 32'(frame_done), 32'd1);
        check_output("t6_late_busy", 32'(busy), 32'd0);
        done = 1'b0;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
